// File: rtl/monitor_estado_pkg.sv
// Shared types and constants for the state-stream monitor.
// Decoder patterns are active-low {g,f,e,d,c,b,a}.
package monitor_estado_pkg;

  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    SIGUIENDO = 2'd1,
    FALLA     = 2'd2
  } estado_t;

  localparam logic [6:0] SEG_CERO = 7'b1000000;
  localparam logic [6:0] SEG_UNO  = 7'b1111001;
  localparam logic [6:0] SEG_DOS  = 7'b0100100;
  localparam logic [6:0] SEG_TRES = 7'b0110000;

  function automatic logic esLegal(
    input logic [1:0] previo,
    input logic [1:0] actual
  );
    logic [1:0] siguiente;
    siguiente = previo + 2'd1;
    return (actual == siguiente) || (actual == 2'd0);
  endfunction

endpackage

// File: rtl/monitor_estado_7seg.sv
// Combinational 2-bit to active-low 7-segment decoder.
// Shared with other display blocks.
module decodificador_7seg
  import monitor_estado_pkg::*;
(
  input  logic [1:0] iValor,
  output logic [6:0] oSegmentos
);

  always_comb begin
    oSegmentos = SEG_CERO;
    unique case (iValor)
      2'd0: oSegmentos = SEG_CERO;
      2'd1: oSegmentos = SEG_UNO;
      2'd2: oSegmentos = SEG_DOS;
      2'd3: oSegmentos = SEG_TRES;
    endcase
  end

endmodule

// File: rtl/monitor_estado.sv
// Consumer-side monitor of the 2-bit state stream: dwell time,
// lap count, sticky sequence/watchdog errors and 7-seg digit.
module monitor_estado
  import monitor_estado_pkg::*;
#(
  parameter int ANCHO_CONT = 16,
  parameter int TIEMPO_MAX = 1000
) (
  input  logic                  iClk,
  input  logic                  iRestart,
  input  logic [1:0]            iValorEstado,
  input  logic                  iPause,
  input  logic                  iBorrarError,
  output logic                  oCambio,
  output logic [1:0]            oEstadoAnterior,
  output logic [ANCHO_CONT-1:0] oPermanencia,
  output logic [7:0]            oVueltas,
  output logic                  oErrorSecuencia,
  output logic                  oErrorTiempo,
  output logic [6:0]            oSegmentos
);

  localparam logic [ANCHO_CONT-1:0] LIMITE = ANCHO_CONT'(TIEMPO_MAX);
  localparam logic [ANCHO_CONT-1:0] MAXIMO = '1;
  localparam logic [ANCHO_CONT-1:0] UNO    = ANCHO_CONT'(1);

  logic [1:0] rMuestra;
  logic [1:0] rPrevia;
  estado_t    rEstado;
  estado_t    estadoSig;
  logic       cambio;
  logic       legal;
  logic       perro;
  logic       vuelta;
  logic       fijaSec;
  logic       fijaTiempo;
  logic       errSecSig;
  logic       errTiempoSig;

  assign cambio = rMuestra != rPrevia;
  assign legal  = esLegal(rPrevia, rMuestra);
  // A detected change takes priority over the watchdog.
  assign perro  = !cambio && !iPause && (oPermanencia == LIMITE);

  always_comb begin
    estadoSig  = rEstado;
    vuelta     = 1'b0;
    fijaSec    = 1'b0;
    fijaTiempo = 1'b0;
    unique case (rEstado)
      ESPERA: begin
        if (cambio) estadoSig = SIGUIENDO;
      end
      SIGUIENDO: begin
        if (cambio && !legal) begin
          fijaSec   = 1'b1;
          estadoSig = FALLA;
        end else if (perro) begin
          fijaTiempo = 1'b1;
          estadoSig  = FALLA;
        end else if (cambio && rPrevia == 2'd3 && rMuestra == 2'd0) begin
          vuelta = 1'b1;
        end
      end
      FALLA: begin
        if (iBorrarError) estadoSig = ESPERA;
      end
      default: estadoSig = ESPERA;
    endcase
    errSecSig    = fijaSec | (oErrorSecuencia & ~iBorrarError);
    errTiempoSig = fijaTiempo | (oErrorTiempo & ~iBorrarError);
  end

  always_ff @(posedge iClk or posedge iRestart) begin
    if (iRestart) begin
      rMuestra        <= 2'd0;
      rPrevia         <= 2'd0;
      rEstado         <= ESPERA;
      oCambio         <= 1'b0;
      oEstadoAnterior <= 2'd0;
      oPermanencia    <= '0;
      oVueltas        <= 8'd0;
      oErrorSecuencia <= 1'b0;
      oErrorTiempo    <= 1'b0;
    end else begin
      rMuestra        <= iValorEstado;
      rPrevia         <= rMuestra;
      rEstado         <= estadoSig;
      oCambio         <= cambio;
      oErrorSecuencia <= errSecSig;
      oErrorTiempo    <= errTiempoSig;
      if (cambio) begin
        oEstadoAnterior <= rPrevia;
        oPermanencia    <= UNO;
      end else if (!iPause && oPermanencia != MAXIMO) begin
        oPermanencia <= oPermanencia + UNO;
      end
      if (vuelta) oVueltas <= oVueltas + 8'd1;
    end
  end

  decodificador_7seg uSeg (
    .iValor    (rMuestra),
    .oSegmentos(oSegmentos)
  );

endmodule

// File: tb/tb_monitor_estado.sv
// Directed bench for monitor_estado: two parameterisations
// share one stimulus and are compared against a behavioural model.
module tb_monitor_estado;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] val = 2'd0;

  always #5 clk = ~clk;

  logic        aCam, bCam, aES, bES, aET, bET;
  logic [1:0]  aAnt, bAnt;
  logic [15:0] aPerm;
  logic [3:0]  bPerm;
  logic [7:0]  aLap, bLap;
  logic [6:0]  aSeg, bSeg;

  monitor_estado #(.ANCHO_CONT(16), .TIEMPO_MAX(8)) dutA (
    .iClk(clk), .iRestart(rst), .iValorEstado(val),
    .iPause(pause), .iBorrarError(clr),
    .oCambio(aCam), .oEstadoAnterior(aAnt),
    .oPermanencia(aPerm), .oVueltas(aLap),
    .oErrorSecuencia(aES), .oErrorTiempo(aET),
    .oSegmentos(aSeg)
  );

  monitor_estado #(.ANCHO_CONT(4), .TIEMPO_MAX(15)) dutB (
    .iClk(clk), .iRestart(rst), .iValorEstado(val),
    .iPause(pause), .iBorrarError(clr),
    .oCambio(bCam), .oEstadoAnterior(bAnt),
    .oPermanencia(bPerm), .oVueltas(bLap),
    .oErrorSecuencia(bES), .oErrorTiempo(bET),
    .oSegmentos(bSeg)
  );

  int dCam[2], dAnt[2], dPerm[2], dLap[2];
  int dES[2], dET[2], dSeg[2];

  always_comb begin
    dCam[0]  = int'(aCam);  dCam[1]  = int'(bCam);
    dAnt[0]  = int'(aAnt);  dAnt[1]  = int'(bAnt);
    dPerm[0] = int'(aPerm); dPerm[1] = int'(bPerm);
    dLap[0]  = int'(aLap);  dLap[1]  = int'(bLap);
    dES[0]   = int'(aES);   dES[1]   = int'(bES);
    dET[0]   = int'(aET);   dET[1]   = int'(bET);
    dSeg[0]  = int'(aSeg);  dSeg[1]  = int'(bSeg);
  end

  int checks = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: history of the last two samples, a mode
  // (0 waiting for first change, 1 tracking, 2 faulted) and counters.
  int segTab[4] = '{64, 121, 36, 48};
  int cap[2]  = '{65535, 15};
  int tmax[2] = '{8, 15};
  int mM[2], mP[2], mModo[2];
  int mCam[2], mAnt[2], mPerm[2], mLap[2], mES[2], mET[2];

  always @(posedge clk or posedge rst) begin
    bit chg, sS, sT;
    int old;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mM[i] = 0; mP[i] = 0; mModo[i] = 0;
        mCam[i] = 0; mAnt[i] = 0; mPerm[i] = 0;
        mLap[i] = 0; mES[i] = 0; mET[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        chg = (mM[i] != mP[i]);
        old = mPerm[i];
        sS = 0; sT = 0;
        mCam[i] = int'(chg);
        if (chg) begin
          mAnt[i] = mP[i];
          mPerm[i] = 1;
        end else if (!pause && mPerm[i] < cap[i]) begin
          mPerm[i] = mPerm[i] + 1;
        end
        if (mModo[i] == 1) begin
          if (chg) begin
            if (!(mM[i] == (mP[i] + 1) % 4 || mM[i] == 0)) begin
              sS = 1; mModo[i] = 2;
            end else if (mP[i] == 3 && mM[i] == 0) begin
              mLap[i] = (mLap[i] + 1) % 256;
            end
          end else if (!pause && old == tmax[i]) begin
            sT = 1; mModo[i] = 2;
          end
        end else if (mModo[i] == 0) begin
          if (chg) mModo[i] = 1;
        end else if (clr) begin
          mModo[i] = 0;
        end
        mES[i] = int'(sS || (mES[i] != 0 && !clr));
        mET[i] = int'(sT || (mET[i] != 0 && !clr));
        mP[i] = mM[i];
        mM[i] = int'(val);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cambio[%0d]", i), dCam[i], mCam[i]);
        chk($sformatf("anterior[%0d]", i), dAnt[i], mAnt[i]);
        chk($sformatf("perm[%0d]", i), dPerm[i], mPerm[i]);
        chk($sformatf("vueltas[%0d]", i), dLap[i], mLap[i]);
        chk($sformatf("errSec[%0d]", i), dES[i], mES[i]);
        chk($sformatf("errTiempo[%0d]", i), dET[i], mET[i]);
        chk($sformatf("seg[%0d]", i), dSeg[i], segTab[mM[i]]);
      end
    end
  end

  int nPulsos = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (aCam) nPulsos++;
    end
  endtask

  task automatic chkReset(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s cambio[%0d]", tag, i), dCam[i], 0);
      chk($sformatf("%s anterior[%0d]", tag, i), dAnt[i], 0);
      chk($sformatf("%s perm[%0d]", tag, i), dPerm[i], 0);
      chk($sformatf("%s vueltas[%0d]", tag, i), dLap[i], 0);
      chk($sformatf("%s errSec[%0d]", tag, i), dES[i], 0);
      chk($sformatf("%s errTiempo[%0d]", tag, i), dET[i], 0);
      chk($sformatf("%s seg[%0d]", tag, i), dSeg[i], 64);
    end
  endtask

  int seqV[5] = '{0, 1, 2, 3, 0};

  initial begin
    #21;
    chkReset("rst");
    #1 rst = 1'b0;

    // nominal lap
    nPulsos = 0;
    for (int k = 0; k < 5; k++) begin
      val = 2'(seqV[k]);
      step(1);
      chk($sformatf("nom seg %0d", k), dSeg[0], segTab[seqV[k]]);
      if (k >= 2) chk($sformatf("nom peak %0d", k), dPerm[0], 5);
      step(4);
    end
    chk("nom pulses", nPulsos, 4);
    chk("nom laps A", dLap[0], 1);
    chk("nom laps B", dLap[1], 1);
    chk("nom errSec", dES[0], 0);

    // illegal jump 1 -> 3
    val = 2'd1; step(3);
    val = 2'd3; step(2);
    chk("illegal errSec", dES[0], 1);
    val = 2'd0; step(3);
    chk("fault lap hold", dLap[0], 1);
    clr = 1'b1; step(1); clr = 1'b0;
    chk("clear errSec", dES[0], 0);
    val = 2'd2; step(3);
    chk("resync errSec", dES[0], 0);
    chk("resync perm", dPerm[0], 2);

    // watchdog and pause
    pause = 1'b1; step(20);
    chk("pause frozen", dPerm[0], 2);
    chk("pause no wd", dET[0], 0);
    pause = 1'b0; step(6);
    chk("wd at limit perm", dPerm[0], 8);
    chk("wd at limit flag", dET[0], 0);
    step(1);
    chk("wd fired", dET[0], 1);
    chk("wd perm", dPerm[0], 9);
    clr = 1'b1; step(1); clr = 1'b0;
    chk("wd cleared", dET[0], 0);

    // illegal change together with clear
    val = 2'd3; step(2);
    val = 2'd1; step(1);
    clr = 1'b1; step(1); clr = 1'b0;
    chk("set wins A", dES[0], 1);
    chk("set wins B", dES[1], 1);

    // change during pause
    clr = 1'b1; step(1); clr = 1'b0;
    pause = 1'b1; val = 2'd2; step(2);
    chk("chg in pause", dPerm[0], 1);
    step(3);
    chk("pause after chg", dPerm[0], 1);

    // saturation on the narrow counter
    pause = 1'b0; step(20);
    chk("sat B", dPerm[1], 15);
    chk("sat B wd", dET[1], 1);
    chk("A wd", dET[0], 1);
    pause = 1'b1; step(5);
    chk("sat B paused", dPerm[1], 15);

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1 chkReset("async");
    step(1);
    rst = 1'b0;
    pause = 1'b0;
    step(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
